// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types, opcodes and helpers for the multiply/divide sequencer
// Optional build macro used by this block: MDU_DIV_ZERO_FAST_EN
package mdu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    localparam int MUL_LAT_DEF = 2;
    localparam int DIV_CYCLES  = 33;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - 32-iteration restoring divider on magnitudes with final sign fix
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_kill,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);

    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;

    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quot_nx;

    assign w_rem_sh  = {r_rem, r_quot[31]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_nx  = w_ge ? 32'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[31:0];
    assign w_quot_nx = {r_quot[30:0], w_ge};

    // Result is presented combinationally during the final iteration so the
    // sequencer can register it on the same edge it enters DONE.
    assign o_done = r_busy && (r_cnt == 5'(DIV_ITER - 1));
    assign o_quot = r_neg_q ? (32'd0 - w_quot_nx) : w_quot_nx;
    assign o_rem  = r_neg_r ? (32'd0 - w_rem_nx)  : w_rem_nx;

    always_ff @(posedge clk) begin
        if (rst || i_kill) begin
            r_busy  <= 1'b0;
            r_cnt   <= 5'd0;
            r_quot  <= 32'd0;
            r_rem   <= 32'd0;
            r_dvs   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= 5'd0;
            r_quot  <= abs32(i_dividend, i_signed);
            r_rem   <= 32'd0;
            r_dvs   <= abs32(i_divisor, i_signed);
            // A zero divisor keeps the all-ones quotient regardless of signs.
            r_neg_q <= i_signed && (i_dividend[31] ^ i_divisor[31]) && (i_divisor != 32'd0);
            r_neg_r <= i_signed && i_dividend[31];
        end else if (r_busy) begin
            r_quot <= w_quot_nx;
            r_rem  <= w_rem_nx;
            r_cnt  <= r_cnt + 5'd1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - EX-stage multiply/divide sequencer with pipeline stall and HI/LO write
// Build macro MDU_DIV_ZERO_FAST_EN: single-cycle divide-by-zero with div_zero_o strobe.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [7:0]  alucontrol_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
`ifdef MDU_DIV_ZERO_FAST_EN
    ,
    output logic        div_zero_o
`endif
);

    localparam logic [3:0] MCNT_INIT = 4'(MUL_LAT - 1);

    mdu_state_e  r_state;
    mdu_state_e  w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;
    logic [3:0]  r_mcnt;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_signed;
    logic        w_start;
    logic        w_dz_fast;
    logic        w_div_start;
    logic        w_div_done;
    logic [31:0] w_div_quot;
    logic [31:0] w_div_rem;
    logic [31:0] w_ma;
    logic [31:0] w_mb;
    logic        w_ms;
    logic [63:0] w_prod;

    assign w_is_mul    = (alucontrol_i == EXE_MULT_OP) || (alucontrol_i == EXE_MULTU_OP);
    assign w_is_div    = (alucontrol_i == EXE_DIV_OP)  || (alucontrol_i == EXE_DIVU_OP);
    assign w_is_signed = (alucontrol_i == EXE_MULT_OP) || (alucontrol_i == EXE_DIV_OP);
    assign w_start     = valid_i && !flush_i && (r_state == ST_IDLE) && (w_is_mul || w_is_div);

`ifdef MDU_DIV_ZERO_FAST_EN
    logic r_dz;
    assign w_dz_fast  = w_is_div && (src_b_i == 32'd0);
    assign div_zero_o = hilo_we_o && r_dz;
`else
    assign w_dz_fast  = 1'b0;
`endif

    assign w_div_start = w_start && w_is_div && !w_dz_fast;

    // Live operands are only needed when a single-cycle multiply finishes from IDLE.
    assign w_ma   = (r_state == ST_IDLE) ? src_a_i     : r_a;
    assign w_mb   = (r_state == ST_IDLE) ? src_b_i     : r_b;
    assign w_ms   = (r_state == ST_IDLE) ? w_is_signed : r_signed;
    assign w_prod = {(w_ms ? {32{w_ma[31]}} : 32'd0), w_ma}
                  * {(w_ms ? {32{w_mb[31]}} : 32'd0), w_mb};

    mdu_div_core #(
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_kill     (flush_i),
        .i_start    (w_div_start),
        .i_signed   (w_is_signed),
        .i_dividend (src_a_i),
        .i_divisor  (src_b_i),
        .o_done     (w_div_done),
        .o_quot     (w_div_quot),
        .o_rem      (w_div_rem)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_is_div) begin
                        w_next = w_dz_fast ? ST_DONE : ST_DIV;
                    end else begin
                        w_next = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
                    end
                end
            end
            ST_MUL:  if (r_mcnt == 4'd1) w_next = ST_DONE;
            ST_DIV:  if (w_div_done)     w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (flush_i) begin
            w_next = ST_IDLE;
        end
    end

    assign stall_o   = (w_start || (r_state == ST_MUL) || (r_state == ST_DIV)) && !flush_i;
    assign busy_o    = (r_state != ST_IDLE);
    assign hilo_we_o = (r_state == ST_DONE) && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_signed <= 1'b0;
            r_mcnt   <= 4'd0;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
`ifdef MDU_DIV_ZERO_FAST_EN
            r_dz     <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_a      <= src_a_i;
                r_b      <= src_b_i;
                r_signed <= w_is_signed;
                r_mcnt   <= MCNT_INIT;
            end else if (r_state == ST_MUL) begin
                r_mcnt <= r_mcnt - 4'd1;
            end
            if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
                if (r_state == ST_DIV) begin
                    hi_o <= w_div_rem;
                    lo_o <= w_div_quot;
                end else if (w_dz_fast) begin
                    hi_o <= src_a_i;
                    lo_o <= 32'hFFFF_FFFF;
                end else begin
                    hi_o <= w_prod[63:32];
                    lo_o <= w_prod[31:0];
                end
`ifdef MDU_DIV_ZERO_FAST_EN
                r_dz <= w_dz_fast;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed self-checking bench for mdu_seq
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        busy;
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_DIV_ZERO_FAST_EN
    logic        dz;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic seen_we;

    always #5 clk = ~clk;

    mdu_seq #(
        .MUL_LAT  (MUL_LAT_DEF),
        .DIV_ITER (DIV_CYCLES - 1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .valid_i      (valid),
        .alucontrol_i (op),
        .src_a_i      (a),
        .src_b_i      (b),
        .stall_o      (stall),
        .busy_o       (busy),
        .hilo_we_o    (we),
        .hi_o         (hi),
        .lo_o         (lo)
`ifdef MDU_DIV_ZERO_FAST_EN
        ,
        .div_zero_o   (dz)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_assert++;
        assert (obs === expd) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [7:0] o, input logic [31:0] va, input logic [31:0] vb);
        valid = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
    endtask

    // Runs T1..T32 with scrambled operands, then steps into T33 (expected DONE).
    task automatic div_wait();
        for (int k = 1; k <= 32; k++) begin
            next();
            a = $urandom;
            b = $urandom;
            settle();
            chk("div_stall", {31'd0, stall}, 32'd1);
            chk("div_no_we", {31'd0, we}, 32'd0);
        end
        next();
        settle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; op = 8'h00; a = 32'd0; b = 32'd0;
        next(); next(); settle();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_we",    {31'd0, we},    32'd0);
        chk("rst_hi",    hi, 32'd0);
        chk("rst_lo",    lo, 32'd0);
        rst = 1'b0;

        next(); issue(8'h20, 32'd1, 32'd2); settle();
        chk("other_op_stall", {31'd0, stall}, 32'd0);
        next(); settle();
        chk("other_op_busy", {31'd0, busy}, 32'd0);

        next(); issue(EXE_MULT_OP, 32'hFFFF_FFFE, 32'd3); settle();
        chk("mult_t0_stall", {31'd0, stall}, 32'd1);
        chk("mult_t0_busy",  {31'd0, busy},  32'd0);
        next(); a = 32'd0; b = 32'd0; settle();
        chk("mult_t1_stall", {31'd0, stall}, 32'd1);
        chk("mult_t1_we",    {31'd0, we},    32'd0);
        next(); settle();
        chk("mult_t2_we",    {31'd0, we},    32'd1);
        chk("mult_t2_stall", {31'd0, stall}, 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        next(); valid = 1'b0; settle();
        chk("mult_t3_busy", {31'd0, busy}, 32'd0);
        chk("mult_t3_we",   {31'd0, we},   32'd0);
        chk("mult_hold_lo", lo, 32'hFFFF_FFFA);

        next(); issue(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        next(); next(); settle();
        chk("multu_we", {31'd0, we}, 32'd1);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        next(); issue(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2); settle();
        chk("div_t0_stall", {31'd0, stall}, 32'd1);
        div_wait();
        chk("div_t33_we",    {31'd0, we},    32'd1);
        chk("div_t33_stall", {31'd0, stall}, 32'd0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        next(); valid = 1'b0; settle();
        chk("div_no_restart", {31'd0, busy}, 32'd0);

        next(); issue(EXE_DIVU_OP, 32'h8000_0000, 32'hFFFF_FFFF);
        div_wait();
        chk("divu_we", {31'd0, we}, 32'd1);
        chk("divu_lo", lo, 32'h0000_0000);
        chk("divu_hi", hi, 32'h8000_0000);
        next(); issue(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF); settle();
        chk("b2b_stall", {31'd0, stall}, 32'd1);
        chk("b2b_busy",  {31'd0, busy},  32'd0);
        div_wait();
        chk("ovf_we", {31'd0, we}, 32'd1);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0000_0000);

        next(); issue(EXE_DIV_OP, 32'd100, 32'd3);
        for (int k = 1; k <= 9; k++) next();
        next(); flush = 1'b1; settle();
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_we",    {31'd0, we},    32'd0);
        next(); flush = 1'b0; valid = 1'b0; settle();
        chk("flush_idle", {31'd0, busy}, 32'd0);
        seen_we = 1'b0;
        for (int k = 0; k < 40; k++) begin
            next(); settle();
            if (we) seen_we = 1'b1;
        end
        chk("flush_never_we", {31'd0, seen_we}, 32'd0);
        chk("flush_lo_held",  lo, 32'h8000_0000);
        next(); issue(EXE_MULT_OP, 32'd5, 32'd7);
        next(); next(); settle();
        chk("post_flush_we", {31'd0, we}, 32'd1);
        chk("post_flush_hi", hi, 32'd0);
        chk("post_flush_lo", lo, 32'd35);

        next(); issue(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd0);
`ifdef MDU_DIV_ZERO_FAST_EN
        next(); settle();
        chk("dz_fast_dz", {31'd0, dz}, 32'd1);
`else
        settle();
        chk("dz_t0_stall", {31'd0, stall}, 32'd1);
        div_wait();
`endif
        chk("dz_we", {31'd0, we}, 32'd1);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        chk("dz_hi", hi, 32'hFFFF_FFF9);
        next(); valid = 1'b0;

        next(); issue(EXE_DIVU_OP, 32'd1234, 32'd5);
        for (int k = 0; k < 5; k++) next();
        rst = 1'b1; valid = 1'b0;
        next(); settle();
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy},  32'd0);
        chk("mid_rst_we",    {31'd0, we},    32'd0);
        chk("mid_rst_hi",    hi, 32'd0);
        chk("mid_rst_lo",    lo, 32'd0);
        rst = 1'b0;
        next(); settle();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
